// File: rtl/game_period_ctrl.sv
// Timed symbol-generation round controller: 1 s prescaler, pause/abort/restart,
// special-symbol counter and N-digit shifting display register.
module game_period_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned PERIOD_SEC    = 15,
   parameter int unsigned TIME_W        = 8,
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned SEG_W         = 8,
   parameter int unsigned CNT_W         = 8,
   parameter logic [SEG_W-1:0] BLANK_SEG = 8'b00000001
) (
   input  logic                        Clk100M,
   input  logic                        RstN,
   input  logic                        gameSig,
   input  logic                        abortSig,
   input  logic                        pauseSig,
   input  logic                        generated,
   input  logic                        special,
   input  logic [SEG_W-1:0]            generatedSym,
   output logic                        genEn,
   output logic                        startGen,
   output logic                        stopGen,
   output logic                        answerSig,
   output logic [CNT_W-1:0]            numSpecial,
   output logic [TIME_W-1:0]           timeLeft,
   output logic [NUM_DIGITS*SEG_W-1:0] gameSegs,
   output logic                        busy
);

   localparam int unsigned PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned DISP_W = NUM_DIGITS * SEG_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   state_t             r_state;
   logic [PW-1:0]      r_presc;
   logic               w_abort;
   logic               w_active;
   logic               w_tick;
   logic               w_accept;
   logic [DISP_W-1:0]  w_shifted;
   logic [DISP_W-1:0]  w_blank;

   assign w_blank  = {NUM_DIGITS{BLANK_SEG}};
   // Abort only means something while a round is in progress.
   assign w_abort  = abortSig && (r_state != S_IDLE);
   // Leaving PAUSE counts on the same edge, so a pause costs exactly its high cycles.
   assign w_active = (r_state == S_RUN) || ((r_state == S_PAUSE) && !pauseSig);
   assign w_tick   = w_active && (r_presc == PW'(TICKS_PER_SEC - 1));
   assign w_accept = generated && (r_state == S_RUN);

   // Digit 0 takes the new symbol, older digits move up one place.
   always_comb begin
      w_shifted = '0;
      w_shifted[SEG_W-1:0] = generatedSym;
      for (int k = 1; k < int'(NUM_DIGITS); k++) begin
         w_shifted[k*SEG_W +: SEG_W] = gameSegs[(k-1)*SEG_W +: SEG_W];
      end
   end

   always_ff @(posedge Clk100M or negedge RstN) begin
      if (!RstN) begin
         r_state    <= S_IDLE;
         r_presc    <= '0;
         genEn      <= 1'b0;
         startGen   <= 1'b0;
         stopGen    <= 1'b0;
         answerSig  <= 1'b0;
         numSpecial <= '0;
         timeLeft   <= '0;
         gameSegs   <= w_blank;
         busy       <= 1'b0;
      end else begin
         startGen  <= 1'b0;
         stopGen   <= 1'b0;
         answerSig <= 1'b0;

         if (w_accept) begin
            gameSegs <= w_shifted;
            if (special && (numSpecial != '1)) numSpecial <= numSpecial + CNT_W'(1);
         end

         // Restart assignments come after the accept so the clear wins.
         if (w_abort) begin
            r_state <= S_IDLE;
            genEn   <= 1'b0;
            busy    <= 1'b0;
            stopGen <= 1'b1;
         end else if (gameSig) begin
            r_state    <= S_RUN;
            genEn      <= 1'b1;
            busy       <= 1'b1;
            startGen   <= 1'b1;
            timeLeft   <= TIME_W'(PERIOD_SEC);
            r_presc    <= '0;
            numSpecial <= '0;
            gameSegs   <= w_blank;
         end else if (r_state != S_IDLE) begin
            if (w_tick) begin
               r_presc <= '0;
               if (timeLeft == TIME_W'(1)) begin
                  r_state   <= S_IDLE;
                  timeLeft  <= '0;
                  genEn     <= 1'b0;
                  busy      <= 1'b0;
                  stopGen   <= 1'b1;
                  answerSig <= 1'b1;
               end else begin
                  r_state  <= S_RUN;
                  timeLeft <= timeLeft - TIME_W'(1);
                  genEn    <= 1'b1;
               end
            end else if (pauseSig) begin
               r_state <= S_PAUSE;
               genEn   <= 1'b0;
            end else begin
               r_state <= S_RUN;
               r_presc <= r_presc + PW'(1);
               genEn   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_game_period_ctrl.sv
// Directed bench for game_period_ctrl with 4 ticks/s, 3 s rounds, 4 digits, 2-bit counter.
module tb_game_period_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        game_sig, abort_sig, pause_sig, generated, special;
   logic [7:0]  sym;
   logic        gen_en, start_gen, stop_gen, answer_sig, busy;
   logic [1:0]  num_special;
   logic [7:0]  time_left;
   logic [31:0] segs;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [31:0] BLANK = 32'h01010101;

   game_period_ctrl #(
      .TICKS_PER_SEC(4), .PERIOD_SEC(3), .TIME_W(8),
      .NUM_DIGITS(4), .SEG_W(8), .CNT_W(2), .BLANK_SEG(8'h01)
   ) dut (
      .Clk100M(clk), .RstN(rst_n), .gameSig(game_sig), .abortSig(abort_sig),
      .pauseSig(pause_sig), .generated(generated), .special(special),
      .generatedSym(sym), .genEn(gen_en), .startGen(start_gen), .stopGen(stop_gen),
      .answerSig(answer_sig), .numSpecial(num_special), .timeLeft(time_left),
      .gameSegs(segs), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sym_in(input logic [7:0] s, input logic sp);
      generated = 1'b1; special = sp; sym = s;
      step(1);
      generated = 1'b0; special = 1'b0;
   endtask

   task automatic start_round();
      game_sig = 1'b1;
      step(1);
      game_sig = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; game_sig = 0; abort_sig = 0; pause_sig = 0;
      generated = 0; special = 0; sym = 8'h00;
      step(2);
      chk("rst_genEn", gen_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeLeft", time_left, 0);
      chk("rst_numSpecial", num_special, 0);
      chk("rst_segs", segs, BLANK);
      chk("rst_stopGen", stop_gen, 0);
      rst_n = 1'b1;
      step(1);

      // Plain round: pulse 12 cycles after first RUN cycle
      start_round();
      chk("t1_startGen", start_gen, 1);
      chk("t1_genEn", gen_en, 1);
      chk("t1_timeLeft", time_left, 3);
      chk("t1_busy", busy, 1);
      step(1);
      chk("t1_startGen_off", start_gen, 0);
      step(10);
      chk("t1_stop_early", stop_gen, 0);
      chk("t1_time_e11", time_left, 1);
      step(1);
      chk("t1_stopGen", stop_gen, 1);
      chk("t1_answerSig", answer_sig, 1);
      chk("t1_timeLeft0", time_left, 0);
      chk("t1_genEn_off", gen_en, 0);
      chk("t1_busy_off", busy, 0);
      step(1);
      chk("t1_stop_pulse", stop_gen, 0);
      chk("t1_answer_pulse", answer_sig, 0);

      // Symbols and saturation
      start_round();
      sym_in(8'h11, 0);
      sym_in(8'h22, 1);
      sym_in(8'h33, 0);
      sym_in(8'h44, 1);
      sym_in(8'h55, 1);
      chk("t2_segs", segs, 32'h22334455);
      chk("t2_numSpecial", num_special, 3);
      sym_in(8'h66, 1);
      chk("t2_sat", num_special, 3);
      chk("t2_segs2", segs, 32'h33445566);
      chk("t2_time_before_abort", time_left, 2);

      // Abort with timeLeft=2; coincident symbol still accepted
      abort_sig = 1'b1;
      sym_in(8'h77, 0);
      abort_sig = 1'b0;
      chk("t3_stopGen", stop_gen, 1);
      chk("t3_answer", answer_sig, 0);
      chk("t3_timeLeft", time_left, 2);
      chk("t3_genEn", gen_en, 0);
      chk("t3_segs", segs, 32'h44556677);
      chk("t3_numSpecial", num_special, 3);
      sym_in(8'h88, 1);
      chk("t3_stop_pulse", stop_gen, 0);
      chk("t3_idle_ignore", segs, 32'h44556677);
      chk("t3_time_hold", time_left, 2);

      // Pause 10 cycles delays the timeout by 10
      start_round();
      step(4);
      chk("t4_time_e4", time_left, 2);
      pause_sig = 1'b1;
      step(1);
      chk("t4_genEn_pause", gen_en, 0);
      chk("t4_busy_pause", busy, 1);
      sym_in(8'h99, 1);
      step(8);
      chk("t4_time_frozen", time_left, 2);
      chk("t4_pause_ignore", segs, BLANK);
      pause_sig = 1'b0;
      step(1);
      chk("t4_genEn_resume", gen_en, 1);
      step(6);
      chk("t4_stop_early", stop_gen, 0);
      step(1);
      chk("t4_stopGen", stop_gen, 1);
      chk("t4_answer", answer_sig, 1);

      // Abort and game in the same RUN cycle: abort wins
      start_round();
      step(2);
      abort_sig = 1'b1; game_sig = 1'b1;
      step(1);
      abort_sig = 1'b0; game_sig = 1'b0;
      chk("t5_stopGen", stop_gen, 1);
      chk("t5_startGen", start_gen, 0);
      chk("t5_busy", busy, 0);

      // Restart in RUN clears state and drops coincident symbol
      start_round();
      sym_in(8'h5A, 1);
      chk("t6_num1", num_special, 1);
      game_sig = 1'b1;
      sym_in(8'hA5, 1);
      game_sig = 1'b0;
      chk("t6_startGen", start_gen, 1);
      chk("t6_stopGen", stop_gen, 0);
      chk("t6_num0", num_special, 0);
      chk("t6_segs", segs, BLANK);
      chk("t6_time", time_left, 3);

      // Asynchronous reset between edges
      step(2);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_genEn", gen_en, 0);
      chk("t7_busy", busy, 0);
      chk("t7_timeLeft", time_left, 0);
      chk("t7_segs", segs, BLANK);
      step(1);
      rst_n = 1'b1;
      step(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
